// File: rtl/vec_pkg.sv
// Shared definitions for the vector command sequencer: opcodes, vtype fields,
// sequencer states and small legality helpers.
package vec_pkg;

   localparam logic [1:0] OP_VARITH = 2'd0;
   localparam logic [1:0] OP_VSETVL = 2'd1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_CFG  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int VTYPE_VALID_BIT = 6;
   localparam int VSEW_MSB        = 5;
   localparam int VSEW_LSB        = 3;
   localparam int VLMUL_MSB       = 2;
   localparam int VLMUL_LSB       = 0;

   localparam logic [2:0] VSEW_MAX  = 3'd3;
   localparam logic [2:0] VLMUL_MAX = 3'd3;

   function automatic logic fields_legal(input logic [2:0] vsew, input logic [2:0] vlmul);
      return (vsew <= VSEW_MAX) && (vlmul <= VLMUL_MAX);
   endfunction

   // A register group base must be a multiple of LMUL.
   function automatic logic reg_aligned(input logic [4:0] r, input logic [2:0] vlmul);
      logic [4:0] m;
      m = (5'd1 << vlmul[1:0]) - 5'd1;
      return (r & m) == 5'd0;
   endfunction

endpackage

// File: rtl/vec_beat_calc.sv
// Combinational sizing for one command: granted vl, beat count and the byte
// mask of the final 64-bit beat.
module vec_beat_calc
   import vec_pkg::*;
(
   input  logic [7:0] vl,
   input  logic [2:0] vsew,
   input  logic [2:0] vlmul,
   input  logic [7:0] avl,
   output logic [7:0] vl_grant,
   output logic [3:0] beats,
   output logic [7:0] last_mask
);

   logic [7:0]  vlmax;
   logic [10:0] bytes;
   logic [7:0]  beats_raw;

   always_comb begin
      vlmax     = (8'd8 >> vsew[1:0]) << vlmul[1:0];
      vl_grant  = (avl < vlmax) ? avl : vlmax;
      bytes     = {3'b000, vl} << vsew[1:0];
      beats_raw = 8'((bytes + 11'd7) >> 3);
      // Clamp keeps the beat counter from running past one register group.
      beats     = (beats_raw > 8'd8) ? 4'd8 : beats_raw[3:0];
      last_mask = (bytes[2:0] == 3'd0) ? 8'hFF : ((8'd1 << bytes[2:0]) - 8'd1);
   end

endmodule

// File: rtl/vec_issue_seq.sv
// Vector command sequencer: accepts VSETVL / VARITH commands and drives the
// register file configuration strobe or a per-beat address/write sequence.
module vec_issue_seq
   import vec_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [4:0] cmd_vs1,
   input  logic [4:0] cmd_vs2,
   input  logic [4:0] cmd_vd,
   input  logic [7:0] cmd_avl,
   input  logic [5:0] cmd_vtype,
   input  logic [7:0] vl,
   input  logic [6:0] vtype,
   output logic [4:0] raA,
   output logic [4:0] raB,
   output logic [4:0] wa,
   output logic       wen,
   output logic [7:0] wmask,
   output logic [2:0] beat_idx,
   output logic       last,
   output logic [7:0] cfg_vl,
   output logic [7:0] cfg_avl,
   output logic [6:0] cfg_vtype,
   output logic       done,
   output logic       illegal
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [2:0] beat;
   logic       illegal_q;
   logic       illegal_nxt;
   logic       accept;

   logic [4:0] vs1_q, vs2_q, vd_q;
   logic [7:0] vl_q, avl_q;
   logic [5:0] fields_q;

   logic [7:0] vl_grant;
   logic [3:0] beats;
   logic [7:0] last_mask;
   logic       is_last;

   logic [2:0] cmd_vsew, cmd_vlmul, cur_vsew, cur_vlmul;

   assign accept    = cmd_valid && (state == ST_IDLE);
   assign cmd_vsew  = cmd_vtype[VSEW_MSB:VSEW_LSB];
   assign cmd_vlmul = cmd_vtype[VLMUL_MSB:VLMUL_LSB];
   assign cur_vsew  = vtype[VSEW_MSB:VSEW_LSB];
   assign cur_vlmul = vtype[VLMUL_MSB:VLMUL_LSB];

   always_comb begin
      state_nxt   = state;
      illegal_nxt = illegal_q;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               illegal_nxt = 1'b0;
               if (cmd_op == OP_VSETVL && fields_legal(cmd_vsew, cmd_vlmul)) begin
                  state_nxt = ST_CFG;
               end else if (cmd_op == OP_VARITH && vl == 8'd0) begin
                  state_nxt = ST_DONE;
               end else if (cmd_op == OP_VARITH && vtype[VTYPE_VALID_BIT] &&
                            fields_legal(cur_vsew, cur_vlmul) &&
                            reg_aligned(cmd_vs1, cur_vlmul) &&
                            reg_aligned(cmd_vs2, cur_vlmul) &&
                            reg_aligned(cmd_vd, cur_vlmul)) begin
                  state_nxt = ST_RUN;
               end else begin
                  state_nxt   = ST_DONE;
                  illegal_nxt = 1'b1;
               end
            end
         end
         ST_RUN:  if (is_last) state_nxt = ST_DONE;
         ST_CFG:  state_nxt = ST_DONE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         beat      <= 3'd0;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         illegal_q <= illegal_nxt;
         if (state == ST_RUN && !is_last) beat <= beat + 3'd1;
         else                             beat <= 3'd0;
      end
   end

   // Command and register-file view captured at accept; held for the command.
   always_ff @(posedge clk) begin
      if (accept) begin
         vs1_q    <= cmd_vs1;
         vs2_q    <= cmd_vs2;
         vd_q     <= cmd_vd;
         avl_q    <= cmd_avl;
         vl_q     <= vl;
         fields_q <= (cmd_op == OP_VSETVL) ? cmd_vtype : vtype[5:0];
      end
   end

   vec_beat_calc u_calc (
      .vl        (vl_q),
      .vsew      (fields_q[VSEW_MSB:VSEW_LSB]),
      .vlmul     (fields_q[VLMUL_MSB:VLMUL_LSB]),
      .avl       (avl_q),
      .vl_grant  (vl_grant),
      .beats     (beats),
      .last_mask (last_mask)
   );

   assign is_last = ({1'b0, beat} == (beats - 4'd1));

   always_comb begin
      cmd_ready = 1'b0;
      raA       = 5'd0;
      raB       = 5'd0;
      wa        = 5'd0;
      wen       = 1'b0;
      wmask     = 8'd0;
      beat_idx  = 3'd0;
      last      = 1'b0;
      cfg_vl    = 8'd0;
      cfg_avl   = 8'd0;
      cfg_vtype = 7'd0;
      done      = 1'b0;
      illegal   = 1'b0;
      case (state)
         ST_IDLE: cmd_ready = 1'b1;
         ST_RUN: begin
            raA      = vs1_q + {2'b00, beat};
            raB      = vs2_q + {2'b00, beat};
            wa       = vd_q + {2'b00, beat};
            wen      = 1'b1;
            wmask    = is_last ? last_mask : 8'hFF;
            beat_idx = beat;
            last     = is_last;
         end
         ST_CFG: begin
            cfg_vl    = vl_grant;
            cfg_avl   = avl_q;
            cfg_vtype = {1'b1, fields_q};
         end
         default: begin
            done    = 1'b1;
            illegal = illegal_q;
         end
      endcase
   end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Directed bench for vec_issue_seq: each task drives one scenario and checks
// outputs on the falling edge against hand-computed values.
module tb_vec_issue_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [4:0] cmd_vs1, cmd_vs2, cmd_vd;
   logic [7:0] cmd_avl;
   logic [5:0] cmd_vtype;
   logic [7:0] vl;
   logic [6:0] vtype;
   logic [4:0] raA, raB, wa;
   logic       wen;
   logic [7:0] wmask;
   logic [2:0] beat_idx;
   logic       last;
   logic [7:0] cfg_vl, cfg_avl;
   logic [6:0] cfg_vtype;
   logic       done, illegal;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   vec_issue_seq dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
      .cmd_avl(cmd_avl), .cmd_vtype(cmd_vtype), .vl(vl), .vtype(vtype),
      .raA(raA), .raB(raB), .wa(wa), .wen(wen), .wmask(wmask),
      .beat_idx(beat_idx), .last(last), .cfg_vl(cfg_vl), .cfg_avl(cfg_avl),
      .cfg_vtype(cfg_vtype), .done(done), .illegal(illegal)
   );

   // Offers a command on a falling edge; returns on the falling edge of T+1.
   task automatic send_cmd(input logic [1:0] op, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic [7:0] avl_v, input logic [5:0] vt_c,
                           input logic [7:0] vl_v, input logic [6:0] vt_v);
      @(negedge clk);
      cmd_op = op; cmd_vs1 = s1; cmd_vs2 = s2; cmd_vd = d;
      cmd_avl = avl_v; cmd_vtype = vt_c; vl = vl_v; vtype = vt_v;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_vs1 = 5'd0; cmd_vs2 = 5'd0;
      cmd_vd = 5'd0; cmd_avl = 8'd0; cmd_vtype = 6'd0; vl = 8'd0; vtype = 7'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else passes++;
      checks++; if ({wen, done, illegal, last} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {wen, done, illegal, last}); else passes++;
      checks++; if ({raA, raB, wa, wmask, cfg_vl, cfg_avl, cfg_vtype} !== 45'd0) $display("FAIL reset_data got %h want 0", {raA, raB, wa, wmask, cfg_vl, cfg_avl, cfg_vtype}); else passes++;
   endtask

   task automatic test_vsetvl;
      send_cmd(2'd1, 5'd0, 5'd0, 5'd0, 8'd20, 6'b001001, 8'd0, 7'd0);
      checks++; if (cfg_vl !== 8'd8) $display("FAIL vsetvl_cfg_vl got %0d want 8", cfg_vl); else passes++;
      checks++; if (cfg_avl !== 8'd20) $display("FAIL vsetvl_cfg_avl got %0d want 20", cfg_avl); else passes++;
      checks++; if (cfg_vtype !== 7'b1001001) $display("FAIL vsetvl_cfg_vtype got %b want 1001001", cfg_vtype); else passes++;
      checks++; if ({wen, done, cmd_ready} !== 3'b000) $display("FAIL vsetvl_cfg_flags got %b want 000", {wen, done, cmd_ready}); else passes++;
      @(negedge clk);
      checks++; if ({done, illegal} !== 2'b10) $display("FAIL vsetvl_done got %b want 10", {done, illegal}); else passes++;
      checks++; if (cfg_vtype !== 7'd0) $display("FAIL vsetvl_strobe_drop got %b want 0", cfg_vtype); else passes++;
      @(negedge clk);
      checks++; if ({cmd_ready, done} !== 2'b10) $display("FAIL vsetvl_idle got %b want 10", {cmd_ready, done}); else passes++;
   endtask

   task automatic test_varith_two_beats;
      send_cmd(2'd0, 5'd2, 5'd4, 5'd6, 8'd0, 6'd0, 8'd8, 7'b1001001);
      checks++; if ({wen, raA, raB, wa} !== {1'b1, 5'd2, 5'd4, 5'd6}) $display("FAIL arith_beat0_addr got %b/%0d/%0d/%0d want 1/2/4/6", wen, raA, raB, wa); else passes++;
      checks++; if ({wmask, beat_idx, last} !== {8'hFF, 3'd0, 1'b0}) $display("FAIL arith_beat0_ctl got %h/%0d/%b want ff/0/0", wmask, beat_idx, last); else passes++;
      @(negedge clk);
      checks++; if ({wen, raA, raB, wa} !== {1'b1, 5'd3, 5'd5, 5'd7}) $display("FAIL arith_beat1_addr got %b/%0d/%0d/%0d want 1/3/5/7", wen, raA, raB, wa); else passes++;
      checks++; if ({wmask, beat_idx, last} !== {8'hFF, 3'd1, 1'b1}) $display("FAIL arith_beat1_ctl got %h/%0d/%b want ff/1/1", wmask, beat_idx, last); else passes++;
      @(negedge clk);
      checks++; if ({done, illegal, wen, cmd_ready} !== 4'b1000) $display("FAIL arith_done got %b want 1000", {done, illegal, wen, cmd_ready}); else passes++;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) $display("FAIL arith_next_ready got %b want 1", cmd_ready); else passes++;
   endtask

   task automatic test_tail_mask;
      send_cmd(2'd0, 5'd0, 5'd2, 5'd4, 8'd0, 6'd0, 8'd3, 7'b1010001);
      checks++; if ({wen, wmask, last} !== {1'b1, 8'hFF, 1'b0}) $display("FAIL tail_beat0 got %b/%h/%b want 1/ff/0", wen, wmask, last); else passes++;
      @(negedge clk);
      checks++; if ({wen, wmask, last, wa} !== {1'b1, 8'h0F, 1'b1, 5'd5}) $display("FAIL tail_beat1 got %b/%h/%b/%0d want 1/0f/1/5", wen, wmask, last, wa); else passes++;
      @(negedge clk);
      checks++; if ({done, illegal, wen} !== 3'b100) $display("FAIL tail_done got %b want 100", {done, illegal, wen}); else passes++;
      @(negedge clk);
   endtask

   task automatic test_zero_and_invalid;
      send_cmd(2'd0, 5'd0, 5'd0, 5'd0, 8'd0, 6'd0, 8'd0, 7'b1001001);
      checks++; if ({done, illegal, wen} !== 3'b100) $display("FAIL zero_vl got %b want 100", {done, illegal, wen}); else passes++;
      @(negedge clk);
      send_cmd(2'd0, 5'd0, 5'd0, 5'd0, 8'd0, 6'd0, 8'd8, 7'b0001001);
      checks++; if ({done, illegal, wen} !== 3'b110) $display("FAIL vtype_invalid got %b want 110", {done, illegal, wen}); else passes++;
      @(negedge clk);
      checks++; if ({cmd_ready, illegal, done} !== 3'b100) $display("FAIL invalid_pulse_width got %b want 100", {cmd_ready, illegal, done}); else passes++;
   endtask

   task automatic test_illegal_fields;
      send_cmd(2'd0, 5'd2, 5'd4, 5'd3, 8'd0, 6'd0, 8'd8, 7'b1001001);
      checks++; if ({done, illegal, wen} !== 3'b110) $display("FAIL misaligned_vd got %b want 110", {done, illegal, wen}); else passes++;
      @(negedge clk);
      send_cmd(2'd1, 5'd0, 5'd0, 5'd0, 8'd10, 6'b101000, 8'd0, 7'd0);
      checks++; if ({done, illegal, cfg_vtype} !== {2'b11, 7'd0}) $display("FAIL bad_vsew got %b/%b/%b want 1/1/0000000", done, illegal, cfg_vtype); else passes++;
      @(negedge clk);
      send_cmd(2'd3, 5'd0, 5'd0, 5'd0, 8'd0, 6'd0, 8'd8, 7'b1001001);
      checks++; if ({done, illegal, wen} !== 3'b110) $display("FAIL bad_opcode got %b want 110", {done, illegal, wen}); else passes++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_command;
      send_cmd(2'd0, 5'd0, 5'd4, 5'd8, 8'd0, 6'd0, 8'd32, 7'b1000010);
      checks++; if ({wen, raA, wa} !== {1'b1, 5'd0, 5'd8}) $display("FAIL mid_beat0 got %b/%0d/%0d want 1/0/8", wen, raA, wa); else passes++;
      @(negedge clk);
      checks++; if ({wen, beat_idx, raB} !== {1'b1, 3'd1, 5'd5}) $display("FAIL mid_beat1 got %b/%0d/%0d want 1/1/5", wen, beat_idx, raB); else passes++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({wen, cmd_ready, done} !== 3'b010) $display("FAIL mid_abort got %b want 010", {wen, cmd_ready, done}); else passes++;
      @(negedge clk);
      checks++; if ({wen, done, cfg_vtype[6]} !== 3'b000) $display("FAIL mid_after got %b want 000", {wen, done, cfg_vtype[6]}); else passes++;
   endtask

   initial begin
      test_reset;
      test_vsetvl;
      test_varith_two_beats;
      test_tail_mask;
      test_zero_and_invalid;
      test_illegal_fields;
      test_reset_mid_command;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
